// File: rtl/output_port_arbiter_if.sv
// output_port_arbiter_if
// Bundles the FIFO-side request/data signals and the link-side outputs of one
// router output port. The master modport is the environment side: input FIFOs
// plus the downstream credit return. The slave modport is the arbiter itself.
interface output_port_arbiter_if #(
    parameter int N_IN  = 5,
    parameter int DEPTH = 8,
    parameter int PKT_W = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             ce;
    logic [N_IN-1:0]  i_req;
    logic [PKT_W-1:0] i_data [N_IN];
    logic             i_credit_ret;

    logic [N_IN-1:0]  o_grant;
    logic [PKT_W-1:0] o_data;
    logic             o_data_val;
    logic [CW-1:0]    o_credits;
    logic             o_credit_err;

    modport master (
        output ce,
        output i_req,
        output i_data,
        output i_credit_ret,
        input  o_grant,
        input  o_data,
        input  o_data_val,
        input  o_credits,
        input  o_credit_err
    );

    modport slave (
        input  ce,
        input  i_req,
        input  i_data,
        input  i_credit_ret,
        output o_grant,
        output o_data,
        output o_data_val,
        output o_credits,
        output o_credit_err
    );
endinterface

// File: rtl/output_port_arbiter.sv
// output_port_arbiter
// Round-robin switch allocator and credit tracker for one router output port.
// Each cycle it grants at most one input FIFO head, pops it through o_grant and
// registers the packet onto the output link. Packets are sent only while the
// local credit counter says the downstream input FIFO has a free slot.
// Optional feature macro: CREDIT_BYPASS_EN -- a credit returned while the
// counter is at zero may be spent in the same cycle.

`ifndef INPUT_QUEUE_DEPTH
`define INPUT_QUEUE_DEPTH 8
`endif

module output_port_arbiter #(
    parameter int N_IN  = 5,
    parameter int DEPTH = `INPUT_QUEUE_DEPTH,
    parameter int PKT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output_port_arbiter_if.slave  bus
);

    localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [CW-1:0]    CREDITS_MAX = CW'(DEPTH);
    localparam logic [PTR_W:0]   N_IN_EXT    = (PTR_W + 1)'(N_IN);
    localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(N_IN - 1);

    // Registered state
    logic [CW-1:0]    credits_q,    credits_d;
    logic [PTR_W-1:0] rr_ptr_q,     rr_ptr_d;
    logic [PKT_W-1:0] data_q,       data_d;
    logic             data_val_q,   data_val_d;
    logic             credit_err_q, credit_err_d;

    // Arbitration signals
    logic             credit_ok;
    logic [N_IN-1:0]  cand;
    logic [PTR_W-1:0] cand_idx [N_IN];
    logic [N_IN-1:0]  grant;
    logic [PTR_W-1:0] grant_idx;
    logic             send;
    logic             ret;

    assign ret = bus.i_credit_ret;

    // A zero credit count normally blocks every grant. With the bypass, a
    // credit arriving this very cycle is treated as already available.
`ifdef CREDIT_BYPASS_EN
    assign credit_ok = (credits_q != '0) || ret;
`else
    assign credit_ok = (credits_q != '0);
`endif

    // Reset is folded into the mask so no FIFO is popped on a reset edge.
    assign cand = (bus.ce && !reset && credit_ok) ? bus.i_req : '0;

    // Search order: slot gi holds input (rr_ptr + gi) mod N_IN.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_order
            logic [PTR_W:0] sum;
            assign sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(gi);
            assign cand_idx[gi] = (sum >= N_IN_EXT) ? PTR_W'(sum - N_IN_EXT)
                                                    : sum[PTR_W-1:0];
        end
    endgenerate

    // Pick the first candidate at or after rr_ptr, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        send      = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (!send && cand[cand_idx[k]]) begin
                send      = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
        if (send) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Next-state: packet capture, pointer advance and credit accounting.
    always_comb begin
        credits_d    = credits_q;
        rr_ptr_d     = rr_ptr_q;
        data_d       = data_q;
        data_val_d   = data_val_q;
        credit_err_d = credit_err_q;

        if (bus.ce) begin
            if (send) begin
                data_d     = bus.i_data[grant_idx];
                data_val_d = 1'b1;
                rr_ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
            end else begin
                data_val_d = 1'b0;
            end

            // A send and a return in the same cycle cancel out; with the
            // bypass this also covers spending a credit that arrives at zero.
            if (send && !ret) begin
                credits_d = credits_q - CW'(1);
            end else if (ret && !send) begin
                if (credits_q == CREDITS_MAX) begin
                    credit_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CW'(1);
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q    <= CREDITS_MAX;
            rr_ptr_q     <= '0;
            data_q       <= '0;
            data_val_q   <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            credits_q    <= credits_d;
            rr_ptr_q     <= rr_ptr_d;
            data_q       <= data_d;
            data_val_q   <= data_val_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign bus.o_grant      = grant;
    assign bus.o_data       = data_q;
    assign bus.o_data_val   = data_val_q;
    assign bus.o_credits    = credits_q;
    assign bus.o_credit_err = credit_err_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter
// Directed bench for output_port_arbiter with N_IN=5, DEPTH=8. Inputs change
// 1 time unit after the rising edge; outputs are sampled before the next edge.
// Optional feature macro: CREDIT_BYPASS_EN selects the matching expectations.
module tb_output_port_arbiter;

    localparam int N_IN  = 5;
    localparam int DEPTH = 8;
    localparam int PKT_W = 16;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    output_port_arbiter_if #(.N_IN(N_IN), .DEPTH(DEPTH), .PKT_W(PKT_W)) bus ();

    output_port_arbiter #(.N_IN(N_IN), .DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PKT_W-1:0] pkt(input int i);
        return 16'hA000 + PKT_W'(i) * 16'h0101;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_exp [8] = '{0, 2, 4, 0, 2, 4, 0, 2};

    initial begin
        reset            = 1'b1;
        bus.ce           = 1'b1;
        bus.i_req        = 5'b11111;
        bus.i_credit_ret = 1'b0;
        for (int i = 0; i < N_IN; i++) bus.i_data[i] = pkt(i);
        #1;
        chk("rst_grant0", 32'(bus.o_grant), 32'h0);
        tick();

        // Reset held with all requests asserted
        for (int c = 0; c < 2; c++) begin
            chk("rst_grant",   32'(bus.o_grant),      32'h0);
            chk("rst_credits", 32'(bus.o_credits),    32'd8);
            chk("rst_val",     32'(bus.o_data_val),   32'h0);
            chk("rst_err",     32'(bus.o_credit_err), 32'h0);
            chk("rst_data",    32'(bus.o_data),       32'h0);
            tick();
        end

        // Round-robin across inputs 0, 2, 4 until credits run out
        reset     = 1'b0;
        bus.i_req = 5'b10101;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant",   32'(bus.o_grant),   32'(1 << rr_exp[k]));
            chk("rr_credits", 32'(bus.o_credits), 32'(8 - k));
            tick();
            chk("rr_val",  32'(bus.o_data_val), 32'h1);
            chk("rr_data", 32'(bus.o_data),     32'(pkt(rr_exp[k])));
        end
        chk("rr_empty_grant",   32'(bus.o_grant),   32'h0);
        chk("rr_empty_credits", 32'(bus.o_credits), 32'd0);
        tick();
        chk("rr_idle_val",  32'(bus.o_data_val), 32'h0);
        chk("rr_idle_data", 32'(bus.o_data),     32'(pkt(2)));

        // Starvation then a single credit return
        bus.i_req = 5'b00010;
        #1;
        chk("starve_grant", 32'(bus.o_grant), 32'h0);
        bus.i_credit_ret = 1'b1;
        #1;
`ifdef CREDIT_BYPASS_EN
        chk("bypass_grant", 32'(bus.o_grant), 32'b00010);
        tick();
        bus.i_credit_ret = 1'b0;
        #1;
        chk("bypass_credits", 32'(bus.o_credits),  32'd0);
        chk("bypass_val",     32'(bus.o_data_val), 32'h1);
        chk("bypass_data",    32'(bus.o_data),     32'(pkt(1)));
        chk("bypass_after",   32'(bus.o_grant),    32'h0);
`else
        chk("ret_same_grant", 32'(bus.o_grant), 32'h0);
        tick();
        bus.i_credit_ret = 1'b0;
        #1;
        chk("ret_credits", 32'(bus.o_credits), 32'd1);
        chk("ret_grant",   32'(bus.o_grant),   32'b00010);
        tick();
        chk("ret_used_credits", 32'(bus.o_credits),  32'd0);
        chk("ret_val",          32'(bus.o_data_val), 32'h1);
        chk("ret_data",         32'(bus.o_data),     32'(pkt(1)));
        chk("ret_after",        32'(bus.o_grant),    32'h0);
`endif

        // Rebuild 3 credits, then send and return together for 4 cycles
        bus.i_req        = 5'b00000;
        bus.i_credit_ret = 1'b1;
        repeat (3) tick();
        chk("fill3_credits", 32'(bus.o_credits), 32'd3);
        bus.i_req = 5'b01000;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("sim_grant",   32'(bus.o_grant),   32'b01000);
            chk("sim_credits", 32'(bus.o_credits), 32'd3);
            tick();
            chk("sim_data", 32'(bus.o_data), 32'(pkt(3)));
        end
        chk("sim_end_credits", 32'(bus.o_credits), 32'd3);

        // Refill to DEPTH, then overflow by one return
        bus.i_req = 5'b00000;
        repeat (5) tick();
        bus.i_credit_ret = 1'b0;
        chk("full_credits", 32'(bus.o_credits),    32'd8);
        chk("full_err",     32'(bus.o_credit_err), 32'h0);
        bus.i_credit_ret = 1'b1;
        tick();
        bus.i_credit_ret = 1'b0;
        chk("ovf_credits", 32'(bus.o_credits),    32'd8);
        chk("ovf_err",     32'(bus.o_credit_err), 32'h1);
        repeat (3) tick();
        chk("ovf_sticky", 32'(bus.o_credit_err), 32'h1);

        // Traffic, ce gating, then reset mid-stream
        bus.i_req = 5'b11111;
        #1;
        chk("ce_pre_grant4", 32'(bus.o_grant), 32'b10000);
        tick();
        chk("ce_pre_credits7", 32'(bus.o_credits), 32'd7);
        chk("ce_pre_data4",    32'(bus.o_data),    32'(pkt(4)));
        chk("ce_pre_grant0",   32'(bus.o_grant),   32'b00001);
        tick();
        chk("ce_pre_credits6", 32'(bus.o_credits), 32'd6);
        bus.ce = 1'b0;
        bus.i_credit_ret = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("ce_low_grant", 32'(bus.o_grant), 32'h0);
            tick();
            chk("ce_low_credits", 32'(bus.o_credits), 32'd6);
            chk("ce_low_data",    32'(bus.o_data),    32'(pkt(0)));
        end
        bus.i_credit_ret = 1'b0;
        bus.ce = 1'b1;
        #1;
        chk("ce_resume_grant", 32'(bus.o_grant),      32'b00010);
        chk("ce_resume_err",   32'(bus.o_credit_err), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(bus.o_grant), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_credits", 32'(bus.o_credits),    32'd8);
        chk("post_rst_err",     32'(bus.o_credit_err), 32'h0);
        chk("post_rst_val",     32'(bus.o_data_val),   32'h0);
        chk("post_rst_data",    32'(bus.o_data),       32'h0);
        chk("post_rst_grant",   32'(bus.o_grant),      32'b00001);
        tick();
        chk("post_rst_send_val",     32'(bus.o_data_val), 32'h1);
        chk("post_rst_send_data",    32'(bus.o_data),     32'(pkt(0)));
        chk("post_rst_send_credits", 32'(bus.o_credits),  32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Per-output-port switch allocator and credit tracker for the router. It sits directly downstream of the per-input packet FIFOs: it picks one input FIFO head per cycle round-robin, pops it, and registers the packet onto the output link. It forwards a packet only while the downstream router's input FIFO has a free slot, tracked by a local credit counter. One instance per router output port.

## Interface
Parameters:
- N_IN, 5, number of input ports competing for this output (2..8)
- DEPTH, `INPUT_QUEUE_DEPTH` (8), depth of the downstream input FIFO; the credit counter's initial value

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; when low, all state holds and o_grant is 0
- i_req  in  N_IN  bit i: input FIFO i has a valid head packet routed to this output
- i_data  in  packet_t[N_IN]  head packet of each input FIFO
- i_credit_ret  in  1  downstream FIFO dequeued one packet this cycle; returns one credit
- o_grant  out  N_IN  one-hot or zero, combinational; drives the pop enable (i_en) of input FIFO i
- o_data  out  packet_t  registered output packet
- o_data_val  out  1  o_data holds a new packet this cycle; high for exactly one cycle per packet
- o_credits  out  $clog2(DEPTH+1)  current free-slot count of the downstream FIFO
- o_credit_err  out  1  sticky; set when a credit returns while the counter is already at DEPTH

## Operation
- Reset values:
  - credits = DEPTH
  - rr_ptr = 0
  - o_data = 0
  - o_data_val = 0
  - o_credit_err = 0
  - o_grant follows its combinational definition, so it is 0 while reset is high.
- Arbitration (combinational):
  - Candidate set is i_req, masked to zero when credits == 0, ce == 0, or reset == 1.
  - Search starts at index rr_ptr and wraps modulo N_IN.
  - The first set bit found wins, and only that bit of o_grant is driven high.
- Transfer, on a clock edge with ce high and a grant to input g:
  - o_data <= i_data[g]
  - o_data_val <= 1
  - rr_ptr <= (g+1) mod N_IN
- No grant:
  - o_data_val <= 0
  - o_data holds its value
  - rr_ptr holds
- Credit update, where send = |o_grant and ret = i_credit_ret:
  - send only: credits - 1
  - ret only: credits + 1
  - both: unchanged
  - neither: unchanged
- Credit overflow: ret with credits == DEPTH and no send:
  - credits stays at DEPTH
  - o_credit_err <= 1; it is cleared only by reset
- Width rule: credits never wraps and never goes below 0, because the grant is masked at 0.
- Reset asserted mid-operation:
  - A grant in the reset cycle is suppressed, so no FIFO is popped.
  - All state returns to its reset values on that edge.

## Timing
- Arbitration is combinational: a request to o_grant takes 0 cycles. The input FIFO pops on the same edge that captures o_data.
- Latency from grant to o_data_val is 1 cycle.
- Sustained throughput is 1 packet per cycle while credits > 0.
- A credit returned in cycle t is first usable in cycle t+1, unless CREDIT_BYPASS_EN is defined.
- With DEPTH credits and a credit return loop of 2 cycles, the link runs full rate; no bubbles are required.

## Configuration
- `CREDIT_BYPASS_EN` defined:
  - When credits == 0 and i_credit_ret is high in the same cycle, the grant mask is lifted.
  - One packet is sent in that cycle and credits stays at 0.
- Not defined: a zero credit count blocks all grants for that cycle, regardless of i_credit_ret.

## Test plan
All scenarios use N_IN=5 and DEPTH=8.
- Reset: reset high for 2 cycles with i_req=5'b11111.
  - Required: o_grant=0 throughout, o_credits=8, o_data_val=0, o_credit_err=0.
- Round-robin: i_req=5'b10101 held, no credit returns.
  - Grants required, in order: inputs 0, 2, 4, 0, 2, 4, 0, 2.
  - Then o_grant=0 with o_credits=0.
  - Each o_data equals the granting input's i_data, one cycle later.
- Credit starvation then recovery: from credits=0 with i_req=5'b00010, pulse i_credit_ret for 1 cycle.
  - Without the macro: grant to input 1 in the following cycle, credits back at 0 afterwards.
  - With `CREDIT_BYPASS_EN`: grant in the same cycle as the pulse.
- Simultaneous send and return: credits=3, i_req=5'b01000, i_credit_ret=1 for 4 cycles.
  - Required: input 3 granted every cycle, o_credits stays at 3.
- Credit overflow: at credits=8, i_credit_ret=1 with i_req=0.
  - Required: o_credits stays 8, o_credit_err=1 on the next cycle and stays 1 until reset.
- ce gating and reset mid-stream: during traffic, drop ce for 3 cycles, then assert reset with i_req=5'b11111.
  - While ce is low: o_grant=0, credits and rr_ptr frozen.
  - On reset: o_grant=0 in the reset cycle, and the first grant after reset goes to input 0.
